// File: rtl/dram_iaram_streamer.sv
// rtl/dram_iaram_streamer.sv - sparse IARAM load transmitter
// Streams compressed (value, index) entries from staging SRAM as per-channel lane packets.
module dram_iaram_streamer #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4,
  parameter int NUM_CH    = 8,
  parameter int MAX_CNT   = 64,
  parameter int CNT_W     = $clog2(MAX_CNT) + 1,
  parameter int ADDR_W    = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             cfg_base_addr,
  input  logic [$clog2(NUM_CH):0]       cfg_num_ch,
  input  logic [NUM_CH*CNT_W-1:0]       cfg_ch_count,
  input  logic                          busy,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_rd_addr,
  input  logic [DATA_W+IDX_W-1:0]       mem_rd_data,
  output logic [NUM_LANES-1:0]          out_valid,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic [NUM_LANES*IDX_W-1:0]    out_indices,
  output logic [$clog2(NUM_CH)-1:0]     out_channel,
  output logic                          out_dense,
  output logic                          active,
  output logic                          done
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int NCH_W  = CH_W + 1;
  localparam int LANE_W = $clog2(NUM_LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAITD,
    S_SEND,
    S_NEXTCH,
    S_FIN
  } state_t;

  state_t                       state;
  logic [NCH_W-1:0]             num_ch_q;
  logic [NUM_CH*CNT_W-1:0]      counts_q;
  logic [NCH_W-1:0]             ch;
  logic [ADDR_W-1:0]            addr;
  logic [CNT_W-1:0]             remaining;
  logic [LANE_W:0]              issued;
  logic                         cap_en;
  logic [LANE_W-1:0]            cap_slot;
  logic [NUM_LANES*DATA_W-1:0]  lane_data;
  logic [NUM_LANES*IDX_W-1:0]   lane_idx;
  logic [NUM_LANES-1:0]         mask;
  logic                         done_q;
  logic [NCH_W-1:0]             next_ch;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(MAX_CNT)) ? CNT_W'(MAX_CNT) : c;
  endfunction

  // Channels past the configured table read as empty so the skip path terminates cleanly.
  function automatic logic [CNT_W-1:0] count_of(input logic [NUM_CH*CNT_W-1:0] counts,
                                                input logic [NCH_W-1:0] c);
    if (c < NCH_W'(NUM_CH))
      return clamp_count(counts[int'(c)*CNT_W +: CNT_W]);
    return '0;
  endfunction

  assign next_ch = ch + NCH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      num_ch_q  <= '0;
      counts_q  <= '0;
      ch        <= '0;
      addr      <= '0;
      remaining <= '0;
      issued    <= '0;
      cap_en    <= 1'b0;
      cap_slot  <= '0;
      lane_data <= '0;
      lane_idx  <= '0;
      mask      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cap_en <= 1'b0;
      // Read data lands one cycle after its strobe, into the slot recorded at issue time.
      if (cap_en) begin
        lane_data[int'(cap_slot)*DATA_W +: DATA_W] <= mem_rd_data[DATA_W-1:0];
        lane_idx[int'(cap_slot)*IDX_W +: IDX_W]    <= mem_rd_data[DATA_W +: IDX_W];
        mask[cap_slot]                             <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            num_ch_q  <= cfg_num_ch;
            counts_q  <= cfg_ch_count;
            ch        <= '0;
            addr      <= cfg_base_addr;
            remaining <= clamp_count(cfg_ch_count[CNT_W-1:0]);
            state     <= (cfg_num_ch != '0) ? S_NEXTCH : S_FIN;
          end
        end
        S_NEXTCH: begin
          if (ch == num_ch_q) begin
            state <= S_FIN;
          end else if (remaining == '0) begin
            ch        <= next_ch;
            remaining <= count_of(counts_q, next_ch);
          end else begin
            issued <= '0;
            state  <= S_FILL;
          end
        end
        S_FILL: begin
          addr      <= addr + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
          issued    <= issued + (LANE_W+1)'(1);
          cap_en    <= 1'b1;
          cap_slot  <= issued[LANE_W-1:0];
          if (issued == (LANE_W+1)'(NUM_LANES-1) || remaining == CNT_W'(1))
            state <= S_WAITD;
        end
        S_WAITD: state <= S_SEND;
        S_SEND: begin
          if (!busy) begin
            mask      <= '0;
            lane_data <= '0;
            lane_idx  <= '0;
            issued    <= '0;
            if (remaining != '0) begin
              state <= S_FILL;
            end else begin
              ch        <= next_ch;
              remaining <= count_of(counts_q, next_ch);
              state     <= S_NEXTCH;
            end
          end
        end
        S_FIN: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_en   = (state == S_FILL);
  assign mem_rd_addr = mem_rd_en ? addr : '0;
  assign out_valid   = (state == S_SEND && !busy) ? mask : '0;
  assign out_data    = (state == S_SEND) ? lane_data : '0;
  assign out_indices = (state == S_SEND) ? lane_idx : '0;
  assign out_channel = (state == S_SEND) ? ch[CH_W-1:0] : '0;
  assign out_dense   = 1'b0;
  assign active      = (state != S_IDLE) && (state != S_FIN);
  assign done        = done_q;

endmodule

// File: tb/tb_dram_iaram_streamer.sv
// tb/tb_dram_iaram_streamer.sv - scoreboard bench for dram_iaram_streamer
// Expected packets and read addresses are queued at stimulus time; a negedge monitor pops them.
module tb_dram_iaram_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] cfg_base_addr;
  logic [3:0]  cfg_num_ch;
  logic [55:0] cfg_ch_count;
  logic        busy;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [19:0] mem_rd_data = '0;
  logic [3:0]  out_valid;
  logic [63:0] out_data;
  logic [15:0] out_indices;
  logic [2:0]  out_channel;
  logic        out_dense;
  logic        active;
  logic        done;

  dram_iaram_streamer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_ch(cfg_num_ch), .cfg_ch_count(cfg_ch_count), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_indices(out_indices),
    .out_channel(out_channel), .out_dense(out_dense), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  mask;
    logic [2:0]  ch;
    logic [63:0] data;
    logic [15:0] idx;
  } pkt_t;

  logic [19:0] sram [0:4095];
  pkt_t        exp_q[$];
  logic [11:0] addr_q[$];
  int          cnts[8];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          pkt_cnt = 0;
  int          lane_cnt = 0;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= sram[mem_rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (mem_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) check("unexpected_read", 64'(mem_rd_addr), 64'hFFFF);
        else check("rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
      end
      if (busy && out_valid != '0) check("valid_under_busy", 64'(out_valid), 64'h0);
      if (out_valid != '0) begin
        pkt_t p;
        pkt_cnt++;
        lane_cnt += $countones(out_valid);
        if (exp_q.size() == 0) begin
          check("unexpected_packet", 64'(out_valid), 64'h0);
        end else begin
          p = exp_q.pop_front();
          check("pkt_mask", 64'(out_valid), 64'(p.mask));
          check("pkt_channel", 64'(out_channel), 64'(p.ch));
          check("pkt_data", out_data, p.data);
          check("pkt_indices", 64'(out_indices), 64'(p.idx));
          check("pkt_dense", 64'(out_dense), 64'h0);
        end
      end
    end
  end

  task automatic build(input int base, input int nch);
    int a;
    int n;
    int k;
    pkt_t p;
    logic [19:0] w;
    a = base;
    for (int c = 0; c < nch; c++) begin
      n = (cnts[c] > 64) ? 64 : cnts[c];
      while (n > 0) begin
        k = (n > 4) ? 4 : n;
        p = '0;
        p.ch = 3'(c);
        for (int l = 0; l < k; l++) begin
          w = sram[a];
          p.mask[l] = 1'b1;
          p.data[l*16 +: 16] = w[15:0];
          p.idx[l*4 +: 4] = w[19:16];
          addr_q.push_back(12'(a));
          a = (a + 1) % 4096;
        end
        exp_q.push_back(p);
        n -= k;
      end
    end
  endtask

  task automatic do_start(input int base, input int nch);
    @(negedge clk);
    cfg_base_addr = 12'(base);
    cfg_num_ch = 4'(nch);
    for (int c = 0; c < 8; c++) cfg_ch_count[c*7 +: 7] = 7'(cnts[c]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_pkts_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_addrs_left"}, 64'(addr_q.size()), 64'd0);
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2);
    for (int c = 0; c < 8; c++) cnts[c] = 0;
    cnts[0] = c0;
    cnts[1] = c1;
    cnts[2] = c2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int l0;
    int r0;
    int d0;
    logic [63:0] held;
    rst = 1'b1; start = 1'b0; busy = 1'b0;
    cfg_base_addr = '0; cfg_num_ch = '0; cfg_ch_count = '0;
    for (int a = 0; a < 4096; a++) sram[a] = {4'(a) ^ 4'h5, 16'(a * 3 + 7)};
    sram[12'h010] = {4'd1, 16'd10};
    sram[12'h011] = {4'd2, 16'd20};
    sram[12'h012] = {4'd3, 16'd30};
    sram[12'h013] = {4'd4, 16'd40};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_rd_en", 64'(mem_rd_en), 64'h0);
    check("reset_active", 64'(active), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_data", out_data, 64'h0);

    // Basic load with hand-written expected packet
    set_counts(4, 0, 0);
    exp_q.push_back('{mask: 4'hF, ch: 3'd0, data: {16'd40, 16'd30, 16'd20, 16'd10},
                      idx: {4'd4, 4'd3, 4'd2, 4'd1}});
    for (int a = 16; a < 20; a++) addr_q.push_back(12'(a));
    do_start(12'h010, 1);
    check("active_after_start", 64'(active), 64'h1);
    wait_done("basic", 100);

    // Partial packets, with an ignored start while active
    set_counts(6, 3, 0);
    build(12'h100, 2);
    p0 = pkt_cnt; l0 = lane_cnt;
    do_start(12'h100, 2);
    repeat (2) @(negedge clk);
    cfg_base_addr = 12'h700; cfg_num_ch = 4'd1; cfg_ch_count = 56'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("partial", 100);
    check("partial_pkts", 64'(pkt_cnt - p0), 64'd3);
    check("partial_lanes", 64'(lane_cnt - l0), 64'd9);

    // Zero-count channels are skipped
    set_counts(0, 2, 0);
    build(12'h200, 3);
    p0 = pkt_cnt; l0 = lane_cnt;
    do_start(12'h200, 3);
    wait_done("skip", 100);
    check("skip_pkts", 64'(pkt_cnt - p0), 64'd1);
    check("skip_lanes", 64'(lane_cnt - l0), 64'd2);

    // num_ch=0: done two cycles after start, no reads
    set_counts(5, 0, 0);
    r0 = rd_cnt;
    do_start(12'h000, 0);
    @(negedge clk);
    check("zero_ch_done", 64'(done), 64'h1);
    repeat (4) @(negedge clk);
    check("zero_ch_reads", 64'(rd_cnt - r0), 64'd0);

    // Stall in SEND
    set_counts(4, 0, 0);
    build(12'h300, 1);
    p0 = pkt_cnt;
    busy = 1'b1;
    do_start(12'h300, 1);
    repeat (8) @(negedge clk);
    held = out_data;
    check("stall_data", held, exp_q[0].data);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", out_data, held);
      check("stall_valid", 64'(out_valid), 64'h0);
    end
    busy = 1'b0;
    wait_done("stall", 100);
    check("stall_pkts", 64'(pkt_cnt - p0), 64'd1);

    // Clamp to 64 and address wrap
    set_counts(70, 0, 0);
    build(12'hFFE, 1);
    p0 = pkt_cnt; l0 = lane_cnt;
    do_start(12'hFFE, 1);
    wait_done("clamp", 400);
    check("clamp_pkts", 64'(pkt_cnt - p0), 64'd16);
    check("clamp_lanes", 64'(lane_cnt - l0), 64'd64);

    // Reset mid-FILL abandons the load, then a fresh load completes
    set_counts(8, 0, 0);
    build(12'h400, 1);
    do_start(12'h400, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_rd_en", 64'(mem_rd_en), 64'h0);
    check("rst_active", 64'(active), 64'h0);
    check("rst_data", out_data, 64'h0);
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    build(12'h400, 1);
    p0 = pkt_cnt;
    do_start(12'h400, 1);
    wait_done("after_rst", 100);
    check("after_rst_pkts", 64'(pkt_cnt - p0), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
